riscv_mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer for the RV32I core. It shares one unified instruction/data memory port between the fetch stage (IF) and the load/store stage (DM). It grants one requester at a time, holds the memory command stable until the memory signals ready, and returns data with a one-cycle acknowledge. DM has priority over IF, with a starvation bound so IF is never locked out.

---
 rtl/riscv_mem_arbiter_if.sv | 43 ++++
 rtl/riscv_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of the IF, DM and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; the master modport is its environment's.
`default_nettype none

interface riscv_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );
endinterface

`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (DM): DM-priority
// arbitration with a starvation bound, held commands, one-cycle acks and timeout abort.
`default_nettype none

module riscv_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    riscv_mem_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_MAX   = 8'(TIMEOUT);

    state_e      state_q,     state_d;
    logic        owner_dm_q,  owner_dm_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] dm_rdata_q,  dm_rdata_d;
    logic        if_ack_q,    if_ack_d;
    logic        dm_ack_q,    dm_ack_d;
    logic        bus_err_q,   bus_err_d;
    logic [3:0]  streak_q,    streak_d;
    logic [7:0]  wait_q,      wait_d;

    logic        if_elig;
    logic        dm_elig;
    logic        pick_if;

    // A requester's req is still high in its own ack cycle; mask it there.
    assign if_elig = bus.if_req & ~if_ack_q;
    assign dm_elig = bus.dm_req & ~dm_ack_q;
    assign pick_if = if_elig & (~dm_elig | (streak_q == STREAK_MAX));

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        bus_err_d   = 1'b0;
        streak_d    = streak_q;
        wait_d      = wait_q;

        case (state_q)
            IDLE: begin
                if (if_elig || dm_elig) begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    wait_d    = 8'd0;
                    if (pick_if) begin
                        owner_dm_d  = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_be_d    = 4'hF;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = 32'h0;
                        streak_d    = 4'd0;
                    end else begin
                        owner_dm_d  = 1'b1;
                        mem_we_d    = bus.dm_we;
                        mem_be_d    = bus.dm_be;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        if (if_elig && (streak_q != STREAK_MAX)) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (owner_dm_q) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    // Abort: ack the owner with zero data and flag the error alongside.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (owner_dm_q) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = 32'h0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = 32'h0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            streak_q    <= 4'd0;
            wait_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            bus_err_q   <= bus_err_d;
            streak_q    <= streak_d;
            wait_q      <= wait_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.bus_err   = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized scoreboard bench for riscv_mem_arbiter with a rule-level arbitration model.
`default_nettype none

module tb_riscv_mem_arbiter;

    localparam int LIMIT = 2;
    localparam int TMO   = 8;
    localparam int N_IF  = 40;
    localparam int N_DM  = 40;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        bit          dm;
        logic [31:0] rdata;
        bit          err;
        bit          chk_data;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_mem_arbiter_if bus ();

    riscv_mem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .TIMEOUT      (TMO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    cmd_t if_q[$];
    cmd_t dm_q[$];
    rsp_t rsp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit mon_en  = 1'b0;
    bit resp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory responder: random delay per access, occasionally never answering.
    initial begin
        int   k;
        int   d;
        int   r;
        rsp_t e;
        logic [31:0] data;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        k = 0;
        d = 0;
        forever begin
            @(posedge clk); #1;
            if (!resp_en) begin
                bus.mem_ready = 1'b0;
                k = 0;
            end else if (!bus.mem_req) begin
                k = 0;
                bus.mem_ready = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom;
            end else begin
                if (k == 0) begin
                    r = $urandom_range(0, 9);
                    d = (r < 6) ? (r % 4) : ((r < 8) ? TMO : 1000);
                end
                k++;
                if (k == d + 1) begin
                    data = $urandom;
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = data;
                    e.dm = bus.mem_addr[31];
                    e.rdata = data;
                    e.err = 1'b0;
                    e.chk_data = !(bus.mem_addr[31] && bus.mem_we);
                    e.cyc = cyc + 1;
                    rsp_q.push_back(e);
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    if (k == TMO + 1) begin
                        e.dm = bus.mem_addr[31];
                        e.rdata = 32'h0;
                        e.err = 1'b1;
                        e.chk_data = 1'b1;
                        e.cyc = cyc + 1;
                        rsp_q.push_back(e);
                    end
                end
            end
        end
    end

    // Monitor: grant choice, command capture/stability, and ack scoreboard.
    initial begin
        bit   p_if, p_dm, p_req, e_if, e_dm, want_dm;
        int   streak;
        cmd_t cur, c;
        rsp_t r;
        logic [31:0] rd;
        p_if = 0; p_dm = 0; p_req = 1; streak = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                p_req = 1'b1; p_if = 1'b0; p_dm = 1'b0;
                continue;
            end
            e_if = bus.if_req && !bus.if_ack;
            e_dm = bus.dm_req && !bus.dm_ack;
            if (!p_req) begin
                check(bus.mem_req == (p_if || p_dm), "mem_req_issue", bus.mem_req, p_if || p_dm);
                if (bus.mem_req && (p_if || p_dm)) begin
                    want_dm = p_dm && !(p_if && streak == LIMIT);
                    check(bus.mem_addr[31] == want_dm, "grant_winner", bus.mem_addr[31], want_dm);
                    if (want_dm) begin
                        if (p_if && streak < LIMIT) streak++;
                    end else begin
                        streak = 0;
                    end
                    if ((want_dm ? dm_q.size() : if_q.size()) == 0) begin
                        check(1'b0, "cmd_queue_empty", 0, 1);
                    end else begin
                        c = want_dm ? dm_q.pop_front() : if_q.pop_front();
                        check(bus.mem_addr == c.addr, "mem_addr", bus.mem_addr, c.addr);
                        check(bus.mem_we == c.we, "mem_we", bus.mem_we, c.we);
                        check(bus.mem_be == c.be, "mem_be", bus.mem_be, c.be);
                        check(bus.mem_wdata == c.wdata, "mem_wdata", bus.mem_wdata, c.wdata);
                    end
                    cur.addr = bus.mem_addr; cur.we = bus.mem_we;
                    cur.be = bus.mem_be; cur.wdata = bus.mem_wdata;
                end
            end else if (bus.mem_req) begin
                check(bus.mem_addr == cur.addr && bus.mem_we == cur.we &&
                      bus.mem_be == cur.be && bus.mem_wdata == cur.wdata,
                      "cmd_stable", bus.mem_addr, cur.addr);
            end

            if (bus.if_ack && bus.dm_ack) begin
                check(1'b0, "dual_ack", 32'h3, 32'h1);
            end else if (bus.if_ack || bus.dm_ack) begin
                if (rsp_q.size() == 0) begin
                    check(1'b0, "spurious_ack", {bus.dm_ack, bus.if_ack}, 0);
                end else begin
                    r = rsp_q.pop_front();
                    check(bus.dm_ack == r.dm, "ack_owner", bus.dm_ack, r.dm);
                    check(cyc == r.cyc, "ack_cycle", cyc, r.cyc);
                    check(bus.bus_err == r.err, "bus_err", bus.bus_err, r.err);
                    if (r.chk_data) begin
                        rd = r.dm ? bus.dm_rdata : bus.if_rdata;
                        check(rd == r.rdata, "rdata", rd, r.rdata);
                    end
                end
            end else begin
                if (bus.bus_err) check(1'b0, "lone_bus_err", 1, 0);
                if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                    check(1'b0, "missing_ack", 0, rsp_q[0].cyc);
                    void'(rsp_q.pop_front());
                end
            end
            p_req = bus.mem_req; p_if = e_if; p_dm = e_dm;
        end
    end

    // Stimulus and directed phases.
    initial begin
        int   n;
        int   order[$];
        cmd_t c;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = 0; bus.dm_addr = 0; bus.dm_wdata = 0;

        repeat (3) @(negedge clk);
        check(bus.mem_req == 0 && bus.mem_we == 0 && bus.mem_be == 0, "rst_mem_ctrl", bus.mem_req, 0);
        check(bus.mem_addr == 0, "rst_mem_addr", bus.mem_addr, 0);
        check(bus.if_ack == 0 && bus.dm_ack == 0 && bus.bus_err == 0, "rst_acks",
              {bus.bus_err, bus.dm_ack, bus.if_ack}, 0);
        check(bus.if_rdata == 0 && bus.dm_rdata == 0, "rst_rdata", bus.if_rdata | bus.dm_rdata, 0);

        @(posedge clk); #1;
        rst_n = 1'b1; mon_en = 1'b1; resp_en = 1'b1;

        fork
            begin : g_if_stim
                bit keep;
                int gap, w;
                logic [31:0] a;
                keep = 0;
                for (int i = 0; i < N_IF; i++) begin
                    gap = $urandom_range(0, 3);
                    if (!keep) repeat (gap) begin @(posedge clk); #1; end
                    a = $urandom; a[31] = 1'b0; a[1:0] = 2'b00;
                    bus.if_addr = a; bus.if_req = 1'b1;
                    if_q.push_back('{a, 1'b0, 4'hF, 32'h0});
                    w = 0;
                    do begin @(posedge clk); #1; w++; end while (!bus.if_ack && w < 300);
                    check(bus.if_ack == 1'b1, "if_ack_wait", bus.if_ack, 1);
                    keep = $urandom_range(0, 1);
                    if (!keep) bus.if_req = 1'b0;
                end
                bus.if_req = 1'b0;
            end
            begin : g_dm_stim
                bit keep;
                int gap, w;
                logic [31:0] a, wd;
                logic [3:0]  be;
                logic        we;
                keep = 0;
                for (int i = 0; i < N_DM; i++) begin
                    gap = $urandom_range(0, 3);
                    if (!keep) repeat (gap) begin @(posedge clk); #1; end
                    a = $urandom; a[31] = 1'b1; a[1:0] = 2'b00;
                    wd = $urandom; be = 4'($urandom); we = 1'($urandom);
                    bus.dm_addr = a; bus.dm_wdata = wd; bus.dm_be = be; bus.dm_we = we;
                    bus.dm_req = 1'b1;
                    dm_q.push_back('{a, we, be, wd});
                    w = 0;
                    do begin @(posedge clk); #1; w++; end while (!bus.dm_ack && w < 300);
                    check(bus.dm_ack == 1'b1, "dm_ack_wait", bus.dm_ack, 1);
                    keep = $urandom_range(0, 1);
                    if (!keep) bus.dm_req = 1'b0;
                end
                bus.dm_req = 1'b0;
            end
        join

        repeat (TMO + 6) @(posedge clk);
        #1;
        check(rsp_q.size() == 0 && if_q.size() == 0 && dm_q.size() == 0, "queues_drained",
              rsp_q.size() + if_q.size() + dm_q.size(), 0);

        // Simultaneous IF fetch and DM store: DM must be served first.
        bus.if_addr = 32'h0000_0100; bus.if_req = 1'b1;
        if_q.push_back('{32'h0000_0100, 1'b0, 4'hF, 32'h0});
        bus.dm_addr = 32'h8000_0200; bus.dm_we = 1'b1; bus.dm_be = 4'h3;
        bus.dm_wdata = 32'hAABBCCDD; bus.dm_req = 1'b1;
        dm_q.push_back('{32'h8000_0200, 1'b1, 4'h3, 32'hAABBCCDD});
        n = 0;
        while ((bus.if_req || bus.dm_req) && n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.dm_ack) begin order.push_back(1); bus.dm_req = 1'b0; end
            if (bus.if_ack) begin order.push_back(0); bus.if_req = 1'b0; end
        end
        check(order.size() == 2, "simul_ack_count", order.size(), 2);
        if (order.size() == 2) check(order[0] == 1 && order[1] == 0, "simul_ack_order", order[0], 1);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check(rsp_q.size() == 0 && if_q.size() == 0 && dm_q.size() == 0, "simul_drained",
              rsp_q.size() + if_q.size() + dm_q.size(), 0);

        // Reset in the middle of an access that memory never answers.
        mon_en = 1'b0; resp_en = 1'b0;
        @(posedge clk); #1;
        bus.if_addr = 32'h0000_0100; bus.if_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.mem_req && n < 10);
        check(bus.mem_req == 1'b1, "busy_before_reset", bus.mem_req, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check(bus.mem_req == 0, "rst_async_mem_req", bus.mem_req, 0);
        check(bus.if_ack == 0 && bus.dm_ack == 0 && bus.bus_err == 0, "rst_async_acks",
              {bus.bus_err, bus.dm_ack, bus.if_ack}, 0);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check(bus.mem_req == 0 && bus.if_ack == 0 && bus.dm_ack == 0 && bus.bus_err == 0,
                  "post_reset_idle", {bus.mem_req, bus.bus_err, bus.dm_ack, bus.if_ack}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
